// File: rtl/perm_gen_if.sv
// Stream and load handshake between perm_gen and the consumer of its permutation words.
// The master modport belongs to the consumer; perm_gen takes the slave modport.
interface perm_gen_if #(
    parameter int W  = 3,
    parameter int K  = 4,
    parameter int CW = 5
);
    logic            start;
    logic [W*K-1:0]  sel;
    logic [W*K-1:0]  prm;
    logic            valid;
    logic            ready;
    logic [CW-1:0]   cnt;
    logic            last;
    logic            busy;
    logic            err;

    modport master (
        output start, sel, ready,
        input  prm, valid, cnt, last, busy, err
    );

    modport slave (
        input  start, sel, ready,
        output prm, valid, cnt, last, busy, err
    );
endinterface

// File: rtl/perm_gen.sv
// perm_gen: walks every ordering of CLB_K source indices in lexicographic order, one per handshake.
// Define PERM_GEN_CHECK_EN to reject non-ascending or out-of-range sel at load time.
`ifndef CLB_N
`define CLB_N 6
`endif
`ifndef CLB_M
`define CLB_M 2
`endif
`ifndef CLB_K
`define CLB_K 4
`endif

module perm_gen #(
    parameter int CLB_N = `CLB_N,
    parameter int CLB_M = `CLB_M,
    parameter int CLB_K = `CLB_K
) (
    input  logic      clk,
    input  logic      rst,
    perm_gen_if.slave io_bus
);
    function automatic int fact(input int n);
        int f;
        f = 1;
        for (int m = 2; m <= n; m++) f = f * m;
        return f;
    endfunction

    localparam int NSRC = CLB_M + CLB_N;
    localparam int W    = $clog2(NSRC);
    localparam int CW   = $clog2(fact(CLB_K));
    localparam int IW   = $clog2(CLB_K);

    typedef logic [CLB_K-1:0][W-1:0] arr_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EMIT = 3'd1,
        S_FIND = 3'd2,
        S_SWAP = 3'd3,
        S_REV  = 3'd4
    } state_t;

    // Non-increasing order means this is the final permutation of the sweep.
    function automatic logic is_desc(input arr_t a);
        logic d;
        d = 1'b1;
        for (int e = 0; e < CLB_K - 1; e++) begin
            if (a[e] < a[e+1]) d = 1'b0;
            else               d = d;
        end
        return d;
    endfunction

`ifdef PERM_GEN_CHECK_EN
    function automatic logic sel_ok(input arr_t a);
        logic ok;
        ok = 1'b1;
        for (int e = 0; e < CLB_K; e++) begin
            if (int'(a[e]) >= NSRC) ok = 1'b0;
            else                    ok = ok;
        end
        for (int e = 0; e < CLB_K - 1; e++) begin
            if (a[e] >= a[e+1]) ok = 1'b0;
            else                ok = ok;
        end
        return ok;
    endfunction
`endif

    arr_t          r_a;
    arr_t          w_a_nxt;
    arr_t          w_sel;
    state_t        r_state;
    logic [IW-1:0] r_i, r_j, r_lo, r_hi;
    logic [IW-1:0] w_fi, w_fj;
    logic [IW:0]   w_gap;
    logic [CW-1:0] r_cnt;
    logic          r_valid, r_last, r_busy;
    logic          w_sel_ok, w_load;

    assign w_sel  = io_bus.sel;
    assign w_load = (r_state == S_IDLE) && io_bus.start && w_sel_ok;
    assign w_gap  = {1'b0, r_hi} - {1'b0, r_lo};

`ifdef PERM_GEN_CHECK_EN
    logic r_err;
    assign w_sel_ok   = sel_ok(w_sel);
    assign io_bus.err = r_err;
`else
    assign w_sel_ok   = 1'b1;
    assign io_bus.err = 1'b0;
`endif

    assign io_bus.prm   = r_a;
    assign io_bus.valid = r_valid;
    assign io_bus.cnt   = r_cnt;
    assign io_bus.last  = r_last;
    assign io_bus.busy  = r_busy;

    // Pivot i (rightmost ascent) and swap partner j (rightmost entry above a[i]).
    always_comb begin
        w_fi = '0;
        w_fj = '0;
        for (int e = 0; e < CLB_K - 1; e++) begin
            if (r_a[e] < r_a[e+1]) w_fi = IW'(e);
            else                   w_fi = w_fi;
        end
        for (int e = 1; e < CLB_K; e++) begin
            if ((e > int'(w_fi)) && (r_a[e] > r_a[w_fi])) w_fj = IW'(e);
            else                                          w_fj = w_fj;
        end
    end

    // Next working array: load, pivot swap, or one step of the suffix reversal.
    always_comb begin
        w_a_nxt = r_a;
        case (r_state)
            S_IDLE: begin
                if (w_load) w_a_nxt = w_sel;
                else        w_a_nxt = r_a;
            end
            S_SWAP: begin
                w_a_nxt[r_i] = r_a[r_j];
                w_a_nxt[r_j] = r_a[r_i];
            end
            S_REV: begin
                w_a_nxt[r_lo] = r_a[r_hi];
                w_a_nxt[r_hi] = r_a[r_lo];
            end
            default: w_a_nxt = r_a;
        endcase
    end

    // Control FSM; last is registered from the array value entering EMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_i     <= '0;
            r_j     <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
`ifdef PERM_GEN_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_a <= w_a_nxt;
            case (r_state)
                S_IDLE: begin
                    if (io_bus.start) begin
`ifdef PERM_GEN_CHECK_EN
                        r_err <= ~w_sel_ok;
`endif
                        if (w_sel_ok) begin
                            r_cnt   <= '0;
                            r_valid <= 1'b1;
                            r_busy  <= 1'b1;
                            r_last  <= is_desc(w_a_nxt);
                            r_state <= S_EMIT;
                        end
                    end
                end
                S_EMIT: begin
                    if (io_bus.ready) begin
                        r_valid <= 1'b0;
                        if (r_last) begin
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + CW'(1);
                            r_state <= S_FIND;
                        end
                    end
                end
                S_FIND: begin
                    r_i     <= w_fi;
                    r_j     <= w_fj;
                    r_lo    <= w_fi + IW'(1);
                    r_hi    <= IW'(CLB_K - 1);
                    r_state <= S_SWAP;
                end
                S_SWAP: begin
                    if (r_lo < r_hi) begin
                        r_state <= S_REV;
                    end else begin
                        r_valid <= 1'b1;
                        r_last  <= is_desc(w_a_nxt);
                        r_state <= S_EMIT;
                    end
                end
                S_REV: begin
                    r_lo <= r_lo + IW'(1);
                    r_hi <= r_hi - IW'(1);
                    if (int'(w_gap) <= 2) begin
                        r_valid <= 1'b1;
                        r_last  <= is_desc(w_a_nxt);
                        r_state <= S_EMIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
